// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT frame packer.
package fft_pkg;

  localparam int WIDTH  = 9;
  localparam int POINTS = 512;
  localparam int LANES  = 16;
  localparam int BEATS  = POINTS / LANES;

  // One output beat: LANES signed components.
  typedef logic signed [WIDTH-1:0] lane_arr_t [0:LANES-1];

  // Read-side burst sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fft_frame_bank.sv
// One frame buffer: per-lane RAMs with single-sample write and full-row
// registered read. Each lane is its own memory so a row reads out in one cycle.
module fft_frame_bank #(
  parameter int WIDTH  = 9,
  parameter int LANES  = 16,
  parameter int BEATS  = 32,
  parameter int BEAT_W = 5,
  parameter int LANE_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [BEAT_W-1:0]       wr_beat,
  input  logic [LANE_W-1:0]       wr_lane,
  input  logic signed [WIDTH-1:0] wr_re,
  input  logic signed [WIDTH-1:0] wr_im,
  input  logic                    rd_en,
  input  logic [BEAT_W-1:0]       rd_beat,
  output logic signed [WIDTH-1:0] rd_re [0:LANES-1],
  output logic signed [WIDTH-1:0] rd_im [0:LANES-1]
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [2*WIDTH-1:0]      mem [0:BEATS-1];
      logic signed [WIDTH-1:0] re_reg;
      logic signed [WIDTH-1:0] im_reg;

      // Store the sample addressed to this lane.
      always_ff @(posedge clk) begin
        if (we && (wr_lane == LANE_W'(gi))) begin
          mem[wr_beat] <= {wr_re, wr_im};
        end
      end

      // Registered row read; holds its value when not enabled so the
      // output keeps showing the last beat between bursts.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          re_reg <= '0;
          im_reg <= '0;
        end else if (rd_en) begin
          {re_reg, im_reg} <= mem[rd_beat];
        end
      end

      assign rd_re[gi] = re_reg;
      assign rd_im[gi] = im_reg;
    end
  endgenerate

endmodule

// File: rtl/fft_frame_packer.sv
// Double-buffered packer: collects POINTS serial complex samples into one of
// two banks, then emits the frame as BEATS contiguous LANES-wide beats.
module fft_frame_packer #(
  parameter int WIDTH  = fft_pkg::WIDTH,
  parameter int POINTS = fft_pkg::POINTS,
  parameter int LANES  = fft_pkg::LANES,
  parameter int GAP    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_re,
  input  logic signed [WIDTH-1:0] s_im,
  input  logic                    s_last,
  output logic signed [WIDTH-1:0] out_re [0:LANES-1],
  output logic signed [WIDTH-1:0] out_im [0:LANES-1],
  output logic                    out_valid,
  output logic                    out_frame_start,
  output logic                    frame_err
);

  localparam int BEATS  = POINTS / LANES;
  localparam int LANE_W = $clog2(LANES);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(POINTS);
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

  logic [CNT_W-1:0]  wr_cnt_reg;
  logic              wr_bank_reg;
  logic              rd_bank_reg;
  logic [1:0]        full_reg;
  logic              frame_err_reg;

  fft_pkg::rd_state_e state_reg;
  logic [BEAT_W-1:0] beat_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              out_sel_reg;
  logic              out_valid_reg;
  logic              out_frame_start_reg;

  logic              accept;
  logic              last_slot;
  logic              burst_end;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;

  logic signed [WIDTH-1:0] bank_re [0:1][0:LANES-1];
  logic signed [WIDTH-1:0] bank_im [0:1][0:LANES-1];

  // Ready is low throughout reset, otherwise only when the target bank is full.
  assign s_ready   = !rst && !full_reg[wr_bank_reg];
  assign accept    = s_valid && s_ready;
  assign last_slot = (wr_cnt_reg == CNT_W'(POINTS - 1));
  assign burst_end = (state_reg == fft_pkg::BURST) && (beat_reg == BEAT_W'(BEATS - 1));

  // Bank flag updates: a frame completing on one bank and a burst ending on
  // the other may land in the same cycle; both take effect.
  always_comb begin
    full_set = '0;
    full_clr = '0;
    full_set[wr_bank_reg] = accept && last_slot;
    full_clr[rd_bank_reg] = burst_end;
  end

  // Write side: sample counter, bank ping-pong, full flags and s_last check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_reg    <= '0;
      wr_bank_reg   <= 1'b0;
      full_reg      <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      full_reg <= (full_reg | full_set) & ~full_clr;
      if (accept) begin
        // Framing follows the count; a misplaced s_last only raises the flag.
        if (s_last != last_slot) begin
          frame_err_reg <= 1'b1;
        end
        if (last_slot) begin
          wr_cnt_reg  <= '0;
          wr_bank_reg <= ~wr_bank_reg;
        end else begin
          wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  // Read FSM: stream a full bank row per cycle, then idle for GAP cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg           <= fft_pkg::IDLE;
      beat_reg            <= '0;
      gap_cnt_reg         <= '0;
      rd_bank_reg         <= 1'b0;
      out_sel_reg         <= 1'b0;
      out_valid_reg       <= 1'b0;
      out_frame_start_reg <= 1'b0;
    end else begin
      case (state_reg)
        fft_pkg::IDLE: begin
          out_valid_reg       <= 1'b0;
          out_frame_start_reg <= 1'b0;
          if (full_reg[rd_bank_reg]) begin
            state_reg   <= fft_pkg::BURST;
            beat_reg    <= '0;
            out_sel_reg <= rd_bank_reg;
          end
        end
        fft_pkg::BURST: begin
          out_valid_reg       <= 1'b1;
          out_frame_start_reg <= (beat_reg == '0);
          if (burst_end) begin
            rd_bank_reg <= ~rd_bank_reg;
            gap_cnt_reg <= '0;
            state_reg   <= fft_pkg::GAP;
          end else begin
            beat_reg <= beat_reg + BEAT_W'(1);
          end
        end
        fft_pkg::GAP: begin
          out_valid_reg       <= 1'b0;
          out_frame_start_reg <= 1'b0;
          if (gap_cnt_reg == GAP_W'(GAP - 1)) begin
            state_reg <= fft_pkg::IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end
        default: begin
          state_reg           <= fft_pkg::IDLE;
          out_valid_reg       <= 1'b0;
          out_frame_start_reg <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      fft_frame_bank #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .BEATS (BEATS),
        .BEAT_W(BEAT_W),
        .LANE_W(LANE_W)
      ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (accept && (wr_bank_reg == 1'(gi))),
        .wr_beat(wr_cnt_reg[CNT_W-1:LANE_W]),
        .wr_lane(wr_cnt_reg[LANE_W-1:0]),
        .wr_re  (s_re),
        .wr_im  (s_im),
        .rd_en  ((state_reg == fft_pkg::BURST) && (rd_bank_reg == 1'(gi))),
        .rd_beat(beat_reg),
        .rd_re  (bank_re[gi]),
        .rd_im  (bank_im[gi])
      );
    end

    // Output lanes come from whichever bank the current/last burst read.
    for (gi = 0; gi < LANES; gi++) begin : g_out
      assign out_re[gi] = out_sel_reg ? bank_re[1][gi] : bank_re[0][gi];
      assign out_im[gi] = out_sel_reg ? bank_im[1][gi] : bank_im[0][gi];
    end
  endgenerate

  assign out_valid       = out_valid_reg;
  assign out_frame_start = out_frame_start_reg;
  assign frame_err       = frame_err_reg;

endmodule
